// File: rtl/neander_pkg.sv
// Shared definitions for the Neander control unit: opcode values, ALU
// operation codes, the control FSM state set and the decode path classes.
package neander_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ULA_PASS = 3'd0;
  localparam logic [2:0] ULA_ADD  = 3'd1;
  localparam logic [2:0] ULA_OR   = 3'd2;
  localparam logic [2:0] ULA_AND  = 3'd3;
  localparam logic [2:0] ULA_NOT  = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH_A,
    S_FETCH_R,
    S_FETCH_I,
    S_DECODE,
    S_OPND_A,
    S_OPND_R,
    S_JUMP,
    S_DATA_A,
    S_DATA_R,
    S_STORE,
    S_EXEC,
    S_HALT
  } state_t;

  // What DECODE does with the current instruction.
  typedef enum logic [2:0] {
    PATH_NOP,   // nothing, back to fetch
    PATH_NOT,   // single-cycle accumulator op in DECODE
    PATH_HLT,   // stop
    PATH_SKIP,  // untaken branch: step PC over the operand byte
    PATH_OPND   // fetch the operand byte
  } path_t;

endpackage

// File: rtl/neander_decode.sv
// Combinational opcode classifier for the Neander control unit.
// Ports:
//   opcode_i   instruction opcode (RI[7:4])
//   flag_n_i   N flag, only meaningful while the FSM is in DECODE
//   flag_z_i   Z flag, only meaningful while the FSM is in DECODE
//   path_o     action class taken from DECODE
//   jump_o     operand byte is a jump target (JMP or taken JN/JZ)
//   store_o    instruction is STA
//   ula_op_o   ALU operation for EXEC (or DECODE for NOT)
module neander_decode
  import neander_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    flag_n_i,
  input  logic                    flag_z_i,
  output path_t                   path_o,
  output logic                    jump_o,
  output logic                    store_o,
  output logic [2:0]              ula_op_o
);

  always_comb begin
    path_o   = PATH_NOP;
    jump_o   = 1'b0;
    store_o  = 1'b0;
    ula_op_o = ULA_PASS;
    case (opcode_i)
      OPCODE_WIDTH'(OP_STA): begin
        path_o  = PATH_OPND;
        store_o = 1'b1;
      end
      OPCODE_WIDTH'(OP_LDA): path_o = PATH_OPND;
      OPCODE_WIDTH'(OP_ADD): begin
        path_o   = PATH_OPND;
        ula_op_o = ULA_ADD;
      end
      OPCODE_WIDTH'(OP_OR): begin
        path_o   = PATH_OPND;
        ula_op_o = ULA_OR;
      end
      OPCODE_WIDTH'(OP_AND): begin
        path_o   = PATH_OPND;
        ula_op_o = ULA_AND;
      end
      OPCODE_WIDTH'(OP_NOT): begin
        path_o   = PATH_NOT;
        ula_op_o = ULA_NOT;
      end
      OPCODE_WIDTH'(OP_JMP): begin
        path_o = PATH_OPND;
        jump_o = 1'b1;
      end
      OPCODE_WIDTH'(OP_JN): begin
        path_o = flag_n_i ? PATH_OPND : PATH_SKIP;
        jump_o = flag_n_i;
      end
      OPCODE_WIDTH'(OP_JZ): begin
        path_o = flag_z_i ? PATH_OPND : PATH_SKIP;
        jump_o = flag_z_i;
      end
      OPCODE_WIDTH'(OP_HLT): path_o = PATH_HLT;
      default: path_o = PATH_NOP;  // NOP and undefined opcodes
    endcase
  end

endmodule

// File: rtl/neander_control.sv
// Neander CPU control unit: Moore FSM sequencing fetch, operand fetch,
// data access, execute and halt.
// Ports:
//   clk                     system clock
//   reset                   async active-low reset
//   opcode                  RI[7:4], valid from DECODE onward
//   flag_n, flag_z          flag register outputs, sampled in DECODE only
//   load_rem..load_pc       register enables
//   inc_pc                  PC increment
//   sel_rem                 REM source: 0 = PC, 1 = RDM
//   mem_read, mem_write     memory strobes
//   ula_op                  ALU op (0 pass, 1 add, 2 or, 3 and, 4 not)
//   halted                  high in HALT
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH_A  | REM <- PC
// FETCH_R  | read instruction into RDM, PC++
// FETCH_I  | RI <- RDM
// DECODE   | classify; NOT executes here, untaken branch skips
// OPND_A   | REM <- PC (operand address)
// OPND_R   | read operand into RDM, PC++
// JUMP     | PC <- RDM
// DATA_A   | REM <- RDM (data address)
// DATA_R   | read data into RDM
// STORE    | write AC to memory
// EXEC     | AC/NZ <- ALU result
// HALT     | stopped until reset
module neander_control
  import neander_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_n,
  input  logic                    flag_z,
  output logic                    load_rem,
  output logic                    load_rdm,
  output logic                    load_ri,
  output logic                    load_ac,
  output logic                    load_nz,
  output logic                    load_pc,
  output logic                    inc_pc,
  output logic                    sel_rem,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [2:0]              ula_op,
  output logic                    halted
);

  state_t     state_q;
  logic       jump_q;
  path_t      dec_path;
  logic       dec_jump;
  logic       dec_store;
  logic [2:0] dec_ula;

  neander_decode #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_decode (
    .opcode_i (opcode),
    .flag_n_i (flag_n),
    .flag_z_i (flag_z),
    .path_o   (dec_path),
    .jump_o   (dec_jump),
    .store_o  (dec_store),
    .ula_op_o (dec_ula)
  );

  // jump_q freezes the branch decision at DECODE so later flag changes
  // cannot redirect an instruction already in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH_A;
      jump_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH_A: state_q <= S_FETCH_R;
        S_FETCH_R: state_q <= S_FETCH_I;
        S_FETCH_I: state_q <= S_DECODE;
        S_DECODE: begin
          jump_q <= dec_jump;
          case (dec_path)
            PATH_HLT:  state_q <= S_HALT;
            PATH_OPND: state_q <= S_OPND_A;
            default:   state_q <= S_FETCH_A;
          endcase
        end
        S_OPND_A:  state_q <= S_OPND_R;
        S_OPND_R:  state_q <= jump_q ? S_JUMP : S_DATA_A;
        S_JUMP:    state_q <= S_FETCH_A;
        S_DATA_A:  state_q <= dec_store ? S_STORE : S_DATA_R;
        S_DATA_R:  state_q <= S_EXEC;
        S_STORE:   state_q <= S_FETCH_A;
        S_EXEC:    state_q <= S_FETCH_A;
        S_HALT:    state_q <= S_HALT;
        default:   state_q <= S_FETCH_A;
      endcase
    end
  end

  // Outputs are gated by reset so they drop asynchronously, even though
  // the state register already sits in FETCH_A during reset.
  always_comb begin
    load_rem  = 1'b0;
    load_rdm  = 1'b0;
    load_ri   = 1'b0;
    load_ac   = 1'b0;
    load_nz   = 1'b0;
    load_pc   = 1'b0;
    inc_pc    = 1'b0;
    sel_rem   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ula_op    = ULA_PASS;
    halted    = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH_A, S_OPND_A: load_rem = 1'b1;
        S_FETCH_R, S_OPND_R: begin
          mem_read = 1'b1;
          load_rdm = 1'b1;
          inc_pc   = 1'b1;
        end
        S_FETCH_I: load_ri = 1'b1;
        S_DECODE: begin
          if (dec_path == PATH_NOT) begin
            load_ac = 1'b1;
            load_nz = 1'b1;
            ula_op  = dec_ula;
          end
          if (dec_path == PATH_SKIP) inc_pc = 1'b1;
        end
        S_JUMP: load_pc = 1'b1;
        S_DATA_A: begin
          load_rem = 1'b1;
          sel_rem  = 1'b1;
        end
        S_DATA_R: begin
          mem_read = 1'b1;
          load_rdm = 1'b1;
        end
        S_STORE: mem_write = 1'b1;
        S_EXEC: begin
          load_ac = 1'b1;
          load_nz = 1'b1;
          ula_op  = dec_ula;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neander_control.sv
module tb_neander_control;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       flag_n;
  logic       flag_z;
  logic       load_rem, load_rdm, load_ri, load_ac, load_nz, load_pc;
  logic       inc_pc, sel_rem, mem_read, mem_write, halted;
  logic [2:0] ula_op;

  neander_control #(.OPCODE_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .load_rem  (load_rem),
    .load_rdm  (load_rdm),
    .load_ri   (load_ri),
    .load_ac   (load_ac),
    .load_nz   (load_nz),
    .load_pc   (load_pc),
    .inc_pc    (inc_pc),
    .sel_rem   (sel_rem),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ula_op    (ula_op),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: rem rdm ri ac nz pc inc sel mrd mwr hlt ula[2:0]
  localparam logic [13:0] LREM = 14'h2000;
  localparam logic [13:0] LRDM = 14'h1000;
  localparam logic [13:0] LRI  = 14'h0800;
  localparam logic [13:0] LAC  = 14'h0400;
  localparam logic [13:0] LNZ  = 14'h0200;
  localparam logic [13:0] LPC  = 14'h0100;
  localparam logic [13:0] INC  = 14'h0080;
  localparam logic [13:0] SEL  = 14'h0040;
  localparam logic [13:0] MRD  = 14'h0020;
  localparam logic [13:0] MWR  = 14'h0010;
  localparam logic [13:0] HLT  = 14'h0008;

  logic [13:0] obs_vec;
  assign obs_vec = {load_rem, load_rdm, load_ri, load_ac, load_nz, load_pc,
                    inc_pc, sel_rem, mem_read, mem_write, halted, ula_op};

  logic [13:0] sb_q[$];
  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle outputs of one instruction (up to DECODE for HLT).
  function automatic void push_instr(input logic [3:0] op, input logic n, input logic z);
    sb_q.push_back(LREM);
    sb_q.push_back(LRDM | MRD | INC);
    sb_q.push_back(LRI);
    case (op)
      4'h6: sb_q.push_back(LAC | LNZ | 14'd4);
      4'h8, 4'h9, 4'hA: begin
        if ((op == 4'h9 && !n) || (op == 4'hA && !z)) begin
          sb_q.push_back(INC);
        end else begin
          sb_q.push_back(14'h0);
          sb_q.push_back(LREM);
          sb_q.push_back(LRDM | MRD | INC);
          sb_q.push_back(LPC);
        end
      end
      4'h1: begin
        sb_q.push_back(14'h0);
        sb_q.push_back(LREM);
        sb_q.push_back(LRDM | MRD | INC);
        sb_q.push_back(LREM | SEL);
        sb_q.push_back(MWR);
      end
      4'h2, 4'h3, 4'h4, 4'h5: begin
        sb_q.push_back(14'h0);
        sb_q.push_back(LREM);
        sb_q.push_back(LRDM | MRD | INC);
        sb_q.push_back(LREM | SEL);
        sb_q.push_back(LRDM | MRD);
        case (op)
          4'h2:    sb_q.push_back(LAC | LNZ | 14'd0);
          4'h3:    sb_q.push_back(LAC | LNZ | 14'd1);
          4'h4:    sb_q.push_back(LAC | LNZ | 14'd2);
          default: sb_q.push_back(LAC | LNZ | 14'd3);
        endcase
      end
      default: sb_q.push_back(14'h0);  // NOP, HLT decode, undefined
    endcase
  endfunction

  // Entered at posedge+1 of cycle 1; leaves at posedge+1 after cycle n.
  task automatic run_cycles(input string tag, input int n, input int flip_at);
    for (int c = 1; c <= n; c++) begin
      if (c == flip_at) begin
        flag_n = ~flag_n;
        flag_z = ~flag_z;
      end
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check_eq($sformatf("%s.c%0d.sb_underflow", tag, c), 32'd0, 32'd1);
      end else begin
        check_eq($sformatf("%s.c%0d", tag, c), obs_vec, sb_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic       n;
    logic       z;
    int         flip;
  } instr_t;

  instr_t tbl[18] = '{
    '{4'h2, 1'b0, 1'b0, 0}, '{4'h3, 1'b0, 1'b0, 0}, '{4'h4, 1'b0, 1'b0, 0},
    '{4'h5, 1'b0, 1'b0, 0}, '{4'h6, 1'b0, 1'b0, 0}, '{4'h9, 1'b0, 1'b0, 0},
    '{4'h9, 1'b1, 1'b0, 5}, '{4'hA, 1'b0, 1'b0, 0}, '{4'hA, 1'b0, 1'b1, 5},
    '{4'hA, 1'b1, 1'b0, 0}, '{4'h9, 1'b0, 1'b1, 0}, '{4'h8, 1'b0, 1'b0, 0},
    '{4'hC, 1'b0, 1'b0, 0}, '{4'h7, 1'b0, 1'b0, 0}, '{4'hB, 1'b1, 1'b1, 0},
    '{4'hE, 1'b0, 1'b0, 0}, '{4'h1, 1'b0, 1'b0, 0}, '{4'h0, 1'b1, 1'b1, 0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b0;
    opcode = 4'h0;
    flag_n = 1'b0;
    flag_z = 1'b0;

    // Outputs all zero while reset is held
    repeat (3) sb_q.push_back(14'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("rst.c%0d", c), obs_vec, sb_q.pop_front());
    end
    @(posedge clk);
    #1 reset = 1'b1;

    // Two NOPs: load_rem at 1, load_ri at 3, load_rem again at 5
    push_instr(4'h0, 1'b0, 1'b0);
    push_instr(4'h0, 1'b0, 1'b0);
    run_cycles("nop2", sb_q.size(), 0);

    for (int i = 0; i < 18; i++) begin
      opcode = tbl[i].op;
      flag_n = tbl[i].n;
      flag_z = tbl[i].z;
      push_instr(tbl[i].op, tbl[i].n, tbl[i].z);
      run_cycles($sformatf("op%0h_n%0d_z%0d", tbl[i].op, tbl[i].n, tbl[i].z),
                 sb_q.size(), tbl[i].flip);
    end

    // STA, with reset pulled mid-STORE
    opcode = 4'h1;
    flag_n = 1'b0;
    flag_z = 1'b0;
    push_instr(4'h1, 1'b0, 1'b0);
    run_cycles("sta_rst", 7, 0);
    @(negedge clk);
    check_eq("sta_rst.c8", obs_vec, sb_q.pop_front());
    #1 reset = 1'b0;
    #1;
    check_eq("sta_rst.async_mem_write", mem_write, 1'b0);
    check_eq("sta_rst.async_all", obs_vec, 14'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    opcode = 4'h0;
    push_instr(4'h0, 1'b0, 1'b0);
    run_cycles("after_sta_rst", sb_q.size(), 0);

    // HLT: halted from cycle 5, held for 20 cycles, left only by reset
    opcode = 4'hF;
    push_instr(4'hF, 1'b0, 1'b0);
    repeat (20) sb_q.push_back(HLT);
    run_cycles("hlt", sb_q.size(), 0);
    reset = 1'b0;
    #2;
    check_eq("hlt.rst_halted", halted, 1'b0);
    check_eq("hlt.rst_all", obs_vec, 14'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    opcode = 4'h0;
    push_instr(4'h0, 1'b0, 1'b0);
    run_cycles("after_hlt", sb_q.size(), 0);

    check_eq("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neander_control.md
NEANDER_CONTROL -- requirements
Module: neander_control

Interface
REQ-001 Parameter OPCODE_WIDTH, default 4, width of the opcode field taken from RI[7:4].
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 opcode  input  OPCODE_WIDTH  upper nibble of RI; valid from DECODE onward.
REQ-005 flag_n  input  1  N flag register output.
REQ-006 flag_z  input  1  Z flag register output.
REQ-007 load_rem, load_rdm, load_ri, load_ac, load_nz, load_pc  output  1 each  register enables.
REQ-008 inc_pc  output  1  PC increment enable.
REQ-009 sel_rem  output  1  REM source: 0 = PC, 1 = RDM.
REQ-010 mem_read, mem_write  output  1 each  memory strobes.
REQ-011 ula_op  output  3  ALU op: 0 pass-B, 1 ADD, 2 OR, 3 AND, 4 NOT.
REQ-012 halted  output  1  high while in HALT.

Function
REQ-013 The block SHALL be a Moore FSM; every output SHALL be decoded from current state only, except DECODE outputs, which also depend on opcode/flags.
REQ-014 Any output not listed as active in a state SHALL be 0.
REQ-015 Fetch: FETCH_A (load_rem, sel_rem=0) -> FETCH_R (mem_read, load_rdm, inc_pc) -> FETCH_I (load_ri) -> DECODE.
REQ-016 DECODE, opcode 0x0 NOP or undefined (0x7, 0xB-0xE): no action -> FETCH_A.
REQ-017 DECODE, 0x6 NOT: load_ac, load_nz, ula_op=4 -> FETCH_A.
REQ-018 DECODE, 0xF HLT: -> HALT.
REQ-019 DECODE, 0x9 JN with flag_n=0 or 0xA JZ with flag_z=0: inc_pc (skip operand) -> FETCH_A; flags SHALL be sampled only in DECODE.
REQ-020 DECODE, 0x1-0x5, 0x8, taken JN/JZ: -> OPND_A (load_rem, sel_rem=0) -> OPND_R (mem_read, load_rdm, inc_pc).
REQ-021 After OPND_R, JMP/taken branch: JUMP (load_pc) -> FETCH_A.
REQ-022 After OPND_R, 0x1-0x5: DATA_A (load_rem, sel_rem=1); STA -> STORE (mem_write) -> FETCH_A.
REQ-023 LDA/ADD/OR/AND: DATA_A -> DATA_R (mem_read, load_rdm) -> EXEC (load_ac, load_nz, ula_op 0/1/2/3) -> FETCH_A.
REQ-024 Instruction length in cycles: NOP/NOT/untaken branch 4, JMP/taken 7, STA 8, LDA/ADD/OR/AND 9.
REQ-025 HALT SHALL assert halted only, hold indefinitely, and exit solely via reset.
REQ-026 mem_read and mem_write SHALL never be high in the same cycle; at most one of load_pc/inc_pc SHALL be high per cycle.

Reset
REQ-027 While reset=0 the FSM SHALL be held in FETCH_A and all outputs, including halted, SHALL be forced to 0 asynchronously.
REQ-028 The first rising clk edge after reset returns to 1 SHALL see FETCH_A outputs active (load_rem=1, sel_rem=0).
REQ-029 Reset asserted mid-instruction (including during STORE) SHALL drop mem_write immediately and abandon the instruction.

Structure
REQ-030 Opcode constants, ula_op codes and the state enumeration SHALL live in shared package neander_pkg.
REQ-031 Opcode-to-path decoding SHALL be a combinational sub-module neander_decode; state register and output decode stay in neander_control.

Verification
REQ-032 Reset low 3 cycles then high, opcode=0x0 -> outputs 0 during reset; load_rem at cycle 1; load_ri at cycle 3; load_rem again at cycle 5.
REQ-033 opcode=0x2 -> sequence FETCH_A..EXEC over 9 cycles; EXEC shows load_ac=1, load_nz=1, ula_op=0; mem_write never high.
REQ-034 opcode=0x9, flag_n=0 -> inc_pc in DECODE, 4-cycle instruction; flag_n=1 -> load_pc in cycle 7, no mem_read after OPND_R.
REQ-035 opcode=0x1 -> mem_write=1 exactly in cycle 8, sel_rem=1 in cycle 7; reset pulled low in cycle 8 -> mem_write falls without clock edge.
REQ-036 opcode=0xF -> halted=1 from cycle 5 for 20 cycles, all enables 0; reset pulse -> halted=0, fetch resumes.
REQ-037 opcode=0xC -> behaves as NOP, 4 cycles, no enable other than fetch ones.
